sd_resp_rx: RTL
===============

SD_RESP_RX -- requirements
Module: sd_resp_rx

Interface
REQ-001 Parameter: NCR_MAX, default 64, maximum sd_clk cycles to wait for a response start bit.
REQ-002 sd_clk  input  1  clock; all state changes and sd_cmd sampling on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rx_en  input  1  one-cycle arm pulse, issued when the command transmitter finishes.
REQ-005 long_resp  input  1  frame length: 1 = 136-bit R2, 0 = 48-bit R1/R3/R6/R7; sampled with rx_en.
REQ-006 skip_crc  input  1  1 = CRC not checked (R3); sampled with rx_en.
REQ-007 sd_cmd  input  1  serial response line from the card; idles high.
REQ-008 busy  output  1  high from the cycle after an accepted rx_en until done.
REQ-009 done  output  1  one-cycle pulse; status and data outputs are valid in this cycle.
REQ-010 timeout  output  1  no start bit was seen within NCR_MAX cycles.
REQ-011 crc_err  output  1  received CRC7 does not match the computed CRC7.
REQ-012 frame_err  output  1  transmission bit is not 0, or end bit is not 1.
REQ-013 resp_index  output  6  short frame bits [45:40]; 6'h3F for long frames.
REQ-014 resp_data  output  128  short frame: {96'b0, bits[39:8]}; long frame: bits[127:0].

Function
REQ-015 FSM states: IDLE, WAIT_START, RECV, DONE.
REQ-016 IDLE: rx_en=1 latches long_resp and skip_crc, clears all status flags, clears the wait counter, and moves to WAIT_START.
REQ-017 WAIT_START: each cycle with sd_cmd=1 increments the wait counter; the counter reaching NCR_MAX sets timeout=1 and moves to DONE.
REQ-018 WAIT_START: sd_cmd=0 is the start bit (frame bit N-1, N = 48 or 136); load bit counter with N-2 and move to RECV.
REQ-019 RECV: shift one sd_cmd bit per cycle MSB-first into a 136-bit shift register and decrement the bit counter; after frame bit 0 is sampled, move to DONE.
REQ-020 CRC7: serial CRC with G(x) = x^7+x^3+1, seed 0.
REQ-021 CRC7 coverage, short frame: bits [47:8], including the start bit.
REQ-022 CRC7 coverage, long frame: bits [127:8] only.
REQ-023 CRC7 compare: computed CRC against bits [7:1]; mismatch sets crc_err=1 unless skip_crc was latched as 1, in which case crc_err=0.
REQ-024 frame_err=1 if bit[N-2] (transmission bit) is 1 or bit[0] (end bit) is 0.
REQ-025 resp_index, resp_data, crc_err and frame_err update on the transition into DONE and hold until the next accepted rx_en.
REQ-026 On timeout, resp_index and resp_data are 0, and crc_err and frame_err are 0.
REQ-027 DONE: done=1 and busy=0 for exactly one cycle, then the FSM returns to IDLE.
REQ-028 Latency: start bit sampled at cycle S -> end bit sampled at S+N-1 -> done=1 at S+N.
REQ-029 Timeout latency: done=1 in the cycle after the NCR_MAX-th high sample.
REQ-030 rx_en while busy=1 or in DONE is ignored.
REQ-031 sd_cmd glitches low after the start bit are data, not restarts.
REQ-032 long_resp and skip_crc changes after arming have no effect on the frame in progress.

Reset
REQ-033 reset=1 at any time, including mid-frame, forces IDLE within the same cycle (asynchronous).
REQ-034 reset values: busy=0, done=0, timeout=0, crc_err=0, frame_err=0, resp_index=0, resp_data=0; counters and shift register cleared.
REQ-035 A frame interrupted by reset is discarded with no done pulse; the block needs a new rx_en after reset release.

Verification
REQ-036 R7 frame: rx_en, long_resp=0, skip_crc=0, 3 idle-high cycles, then bytes 08 00 00 01 AA 13 MSB-first -> done at start+48; resp_index=6'h08, resp_data[31:0]=32'h000001AA, crc_err=0, frame_err=0.
REQ-037 R3 frame: skip_crc=1, bytes 3F 80 FF 80 00 FF -> resp_index=6'h3F, resp_data[31:0]=32'h80FF8000, crc_err=0, frame_err=0.
REQ-038 Corrupt CRC: REQ-036 frame with argument bit 0 flipped (..01 AB 13) -> crc_err=1, frame_err=0, resp_data[31:0]=32'h000001AB.
REQ-039 Timeout: rx_en with sd_cmd held high -> done exactly 65 cycles after rx_en (NCR_MAX=64); timeout=1, resp_data=0.
REQ-040 Long R2: long_resp=1, 136-bit frame with reserved bits 111111 and a valid CRC over [127:8] -> done at start+136; resp_data equals sent bits [127:0], resp_index=6'h3F, flags 0.
REQ-041 Framing and reset: end bit driven 0 -> frame_err=1; a second frame with reset pulsed at bit 20 -> all outputs 0, no done pulse; a following good frame is received correctly.

Source files
------------

// File: rtl/sd_resp_rx.sv
// sd_resp_rx -- SD card CMD-line response receiver.
//
// Armed by a one-cycle rx_en pulse once the command has been sent, the block
// waits up to NCR_MAX cycles for the response start bit on sd_cmd. It then
// shifts in a 48-bit (R1/R3/R6/R7) or 136-bit (R2) frame MSB-first, checks
// the CRC7 and the framing bits, and reports the result with a one-cycle
// done pulse. Results hold until the next accepted rx_en.
//
// Ports:
//   sd_clk      clock; sd_cmd is sampled on the rising edge
//   reset       asynchronous, active-high reset
//   rx_en       arm pulse (ignored unless idle)
//   long_resp   1 = 136-bit R2 frame, 0 = 48-bit frame (sampled with rx_en)
//   skip_crc    1 = do not check the CRC, e.g. R3 (sampled with rx_en)
//   sd_cmd      serial response line, idles high
//   busy        waiting for or receiving a frame
//   done        one-cycle completion pulse
//   timeout     no start bit within NCR_MAX cycles
//   crc_err     received CRC7 differs from the computed CRC7
//   frame_err   transmission bit not 0 or end bit not 1
//   resp_index  command index of a short frame, 6'h3F for a long frame
//   resp_data   short: {96'b0, bits[39:8]}; long: bits[127:0]
module sd_resp_rx #(
  parameter int NCR_MAX = 64
) (
  input  logic         sd_clk,
  input  logic         reset,
  input  logic         rx_en,
  input  logic         long_resp,
  input  logic         skip_crc,
  input  logic         sd_cmd,
  output logic         busy,
  output logic         done,
  output logic         timeout,
  output logic         crc_err,
  output logic         frame_err,
  output logic [5:0]   resp_index,
  output logic [127:0] resp_data
);

  localparam int CW = $clog2(NCR_MAX + 1);
  localparam logic [CW-1:0] NCR_LIM = CW'(NCR_MAX);

  typedef enum logic [1:0] {IDLE, WAIT_START, RECV, DONE} state_t;

  state_t         state_q, state_d;
  logic           long_q, long_d;
  logic           skip_q, skip_d;
  logic [CW-1:0]  wait_q, wait_d;
  logic [7:0]     bit_q, bit_d;
  logic [135:0]   sh_q, sh_d;
  logic [6:0]     crc_q, crc_d;
  logic           timeout_q, timeout_d;
  logic           crc_err_q, crc_err_d;
  logic           frame_err_q, frame_err_d;
  logic [5:0]     idx_q, idx_d;
  logic [127:0]   data_q, data_d;

  // Frame bits including the one being sampled this cycle; on the final
  // cycle this is the complete frame, right-aligned.
  logic [135:0]   full;
  assign full = {sh_q[134:0], sd_cmd};

  // Start bit (always 0) and the R2 reserved bits carry no information.
  logic unused_bits;
  assign unused_bits = ^{sh_q[135], full[135], full[133:128]};

  // One step of the serial CRC7, G(x) = x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = crc[6] ^ bit_in;
    return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  always_comb begin
    state_d     = state_q;
    long_d      = long_q;
    skip_d      = skip_q;
    wait_d      = wait_q;
    bit_d       = bit_q;
    sh_d        = sh_q;
    crc_d       = crc_q;
    timeout_d   = timeout_q;
    crc_err_d   = crc_err_q;
    frame_err_d = frame_err_q;
    idx_d       = idx_q;
    data_d      = data_q;

    case (state_q)
      IDLE: begin
        if (rx_en) begin
          long_d      = long_resp;
          skip_d      = skip_crc;
          wait_d      = '0;
          sh_d        = '0;
          crc_d       = '0;
          timeout_d   = 1'b0;
          crc_err_d   = 1'b0;
          frame_err_d = 1'b0;
          idx_d       = '0;
          data_d      = '0;
          state_d     = WAIT_START;
        end
      end

      WAIT_START: begin
        if (!sd_cmd) begin
          // The start bit is 0, so with a zero seed it leaves the CRC at 0;
          // it is covered without an explicit update.
          sh_d    = full;
          bit_d   = long_q ? 8'd134 : 8'd46;
          state_d = RECV;
        end else begin
          wait_d = wait_q + CW'(1);
          if (wait_d == NCR_LIM) begin
            timeout_d = 1'b1;
            state_d   = DONE;
          end
        end
      end

      RECV: begin
        sh_d  = full;
        bit_d = bit_q - 8'd1;
        // bit_q is the frame index of the bit sampled this cycle.
        if (bit_q >= 8'd8 && (!long_q || bit_q <= 8'd127)) begin
          crc_d = crc7_step(crc_q, sd_cmd);
        end
        if (bit_q == 8'd0) begin
          state_d   = DONE;
          crc_err_d = !skip_q && (crc_q != full[7:1]);
          if (long_q) begin
            idx_d       = 6'h3F;
            data_d      = full[127:0];
            frame_err_d = full[134] | ~full[0];
          end else begin
            idx_d       = full[45:40];
            data_d      = {96'b0, full[39:8]};
            frame_err_d = full[46] | ~full[0];
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sd_clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      long_q      <= 1'b0;
      skip_q      <= 1'b0;
      wait_q      <= '0;
      bit_q       <= '0;
      sh_q        <= '0;
      crc_q       <= '0;
      timeout_q   <= 1'b0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      idx_q       <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      long_q      <= long_d;
      skip_q      <= skip_d;
      wait_q      <= wait_d;
      bit_q       <= bit_d;
      sh_q        <= sh_d;
      crc_q       <= crc_d;
      timeout_q   <= timeout_d;
      crc_err_q   <= crc_err_d;
      frame_err_q <= frame_err_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
    end
  end

  assign busy       = (state_q == WAIT_START) || (state_q == RECV);
  assign done       = (state_q == DONE);
  assign timeout    = timeout_q;
  assign crc_err    = crc_err_q;
  assign frame_err  = frame_err_q;
  assign resp_index = idx_q;
  assign resp_data  = data_q;

endmodule
